// File: rtl/frame_classify_sequencer.sv
// Two-pass green-object classifier over the stored RGB frame: pass 1 thresholds every
// pixel into a 1-bit mask plus counters, pass 2 counts row transitions at the leftmost column.
module frame_classify_sequencer #(
  parameter int         HEIGHT      = 20,
  parameter int         WIDTH       = 30,
  parameter int         DEPTH       = 3,
  parameter int         ADDR_W      = 11,
  parameter int         SHIFT       = 2,
  parameter int         LEFT        = 12,
  parameter int         LEFT_THRESH = 120,
  parameter logic [7:0] LO0         = 8'd18,
  parameter logic [7:0] HI0         = 8'd43,
  parameter logic [7:0] LO1         = 8'd25,
  parameter logic [7:0] HI1         = 8'd255,
  parameter logic [7:0] LO2         = 8'd25,
  parameter logic [7:0] HI2         = 8'd255
) (
  input  logic              fpga_clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic [1:0]        result,
  output logic              result_valid,
  input  logic              result_ack,
  output logic [9:0]        total_count,
  output logic [9:0]        left_count,
  output logic [4:0]        leftmost_col,
  output logic [4:0]        num_transitions
);

  localparam int NPIX  = HEIGHT * WIDTH;
  localparam int PIX_W = $clog2(NPIX);
  localparam int TOTAL = NPIX * DEPTH;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [1:0]        LAST_CH   = 2'(DEPTH - 1);
  localparam logic [4:0]        LAST_COL  = 5'(WIDTH - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(HEIGHT - 3);
  localparam logic [4:0]        WIDTH_C   = 5'(WIDTH);
  localparam logic [4:0]        LEFT_C    = 5'(LEFT);
  localparam logic [5:0]        SHIFT_C   = 6'(SHIFT);
  localparam logic [9:0]        THRESH_C  = 10'(LEFT_THRESH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_TRANS = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    in_range = (v >= lo) && (v <= hi);
  endfunction

  // Columns at or beyond WIDTH read as background.
  function automatic logic mask_bit(input logic [NPIX-1:0] m, input logic [4:0] row,
                                    input logic [5:0] col);
    logic [PIX_W-1:0] idx;
    idx = PIX_W'(row) * PIX_W'(WIDTH) + PIX_W'(col);
    if (col < 6'(WIDTH)) begin
      mask_bit = m[idx];
    end else begin
      mask_bit = 1'b0;
    end
  endfunction

  function automatic logic [1:0] classify(input logic [4:0] nt, input logic [9:0] lc);
    if (nt == 5'd4) begin
      classify = 2'b10;
    end else if (lc > THRESH_C) begin
      classify = 2'b01;
    end else begin
      classify = 2'b00;
    end
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        ch_q, ch_d;
  logic [4:0]        col_q, col_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              rvld_q, rvld_d;
  logic [1:0]        rch_q, rch_d;
  logic [4:0]        rcol_q, rcol_d;
  logic [PIX_W-1:0]  rpix_q, rpix_d;
  logic              c0_ok_q, c0_ok_d;
  logic              c1_ok_q, c1_ok_d;
  logic [NPIX-1:0]   mask_q, mask_d;
  logic [4:0]        trow_q, trow_d;
  logic [9:0]        total_q, total_d;
  logic [9:0]        left_q, left_d;
  logic [4:0]        lm_q, lm_d;
  logic [4:0]        nt_q, nt_d;
  logic [1:0]        result_q, result_d;
  logic              valid_q, valid_d;

  logic              start_go_s;
  logic              pix_set_s;
  logic              bit_a_s, bit_b_s;
  logic [5:0]        lcol_s, scol_s;

  // Next-state logic: FSM, read issue, returned-data thresholding and transition pass.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ch_d     = ch_q;
    col_d    = col_q;
    pix_d    = pix_q;
    rvld_d   = 1'b0;
    rch_d    = rch_q;
    rcol_d   = rcol_q;
    rpix_d   = rpix_q;
    c0_ok_d  = c0_ok_q;
    c1_ok_d  = c1_ok_q;
    mask_d   = mask_q;
    trow_d   = trow_q;
    total_d  = total_q;
    left_d   = left_q;
    lm_d     = lm_q;
    nt_d     = nt_q;
    result_d = result_q;
    valid_d  = valid_q;
    pix_set_s = 1'b0;
    lcol_s   = {1'b0, lm_q};
    scol_s   = lcol_s + SHIFT_C;
    bit_a_s  = mask_bit(mask_q, trow_q, lcol_s);
    bit_b_s  = mask_bit(mask_q, trow_q, scol_s);
    start_go_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        rvld_d = 1'b1;
        rch_d  = ch_q;
        rcol_d = col_q;
        rpix_d = pix_q;
        if (ch_q == LAST_CH) begin
          ch_d  = 2'd0;
          pix_d = pix_q + {{(PIX_W-1){1'b0}}, 1'b1};
          col_d = (col_q == LAST_COL) ? 5'd0 : col_q + 5'd1;
        end else begin
          ch_d = ch_q + 2'd1;
        end
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_DRAIN: begin
        trow_d  = 5'd0;
        state_d = S_TRANS;
      end
      S_TRANS: begin
        if ((lm_q != WIDTH_C) && (bit_a_s != bit_b_s)) begin
          nt_d = nt_q + 5'd1;
        end else begin
          nt_d = nt_q;
        end
        if (trow_q == LAST_ROW) begin
          result_d = classify(nt_d, left_q);
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          trow_d = trow_q + 5'd1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_SCAN;
        end else if (result_ack) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read data lags the issued address by one cycle; channels 0/1 are latched as flags.
    if (rvld_q) begin
      case (rch_q)
        2'd0: c0_ok_d = in_range(mem_rdata, LO0, HI0);
        2'd1: c1_ok_d = in_range(mem_rdata, LO1, HI1);
        default: begin
          pix_set_s = c0_ok_q & c1_ok_q & in_range(mem_rdata, LO2, HI2);
          mask_d[rpix_q] = pix_set_s;
          if (pix_set_s) begin
            total_d = total_q + 10'd1;
            if (rcol_q < LEFT_C) begin
              left_d = left_q + 10'd1;
            end else begin
              left_d = left_q;
            end
            if (rcol_q < lm_q) begin
              lm_d = rcol_q;
            end else begin
              lm_d = lm_q;
            end
          end else begin
            total_d = total_q;
          end
        end
      endcase
    end else begin
      rch_d = rch_d;
    end

    if (start_go_s) begin
      addr_d   = '0;
      ch_d     = 2'd0;
      col_d    = 5'd0;
      pix_d    = '0;
      c0_ok_d  = 1'b0;
      c1_ok_d  = 1'b0;
      mask_d   = '0;
      trow_d   = 5'd0;
      total_d  = 10'd0;
      left_d   = 10'd0;
      lm_d     = WIDTH_C;
      nt_d     = 5'd0;
      result_d = 2'b00;
      valid_d  = 1'b0;
    end else begin
      addr_d = addr_d;
    end

    rd_en_d = (state_d == S_SCAN);
    busy_d  = (state_d == S_SCAN) || (state_d == S_DRAIN) || (state_d == S_TRANS);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      ch_q     <= 2'd0;
      col_q    <= 5'd0;
      pix_q    <= '0;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      rvld_q   <= 1'b0;
      rch_q    <= 2'd0;
      rcol_q   <= 5'd0;
      rpix_q   <= '0;
      c0_ok_q  <= 1'b0;
      c1_ok_q  <= 1'b0;
      mask_q   <= '0;
      trow_q   <= 5'd0;
      total_q  <= 10'd0;
      left_q   <= 10'd0;
      lm_q     <= WIDTH_C;
      nt_q     <= 5'd0;
      result_q <= 2'b00;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ch_q     <= ch_d;
      col_q    <= col_d;
      pix_q    <= pix_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      rvld_q   <= rvld_d;
      rch_q    <= rch_d;
      rcol_q   <= rcol_d;
      rpix_q   <= rpix_d;
      c0_ok_q  <= c0_ok_d;
      c1_ok_q  <= c1_ok_d;
      mask_q   <= mask_d;
      trow_q   <= trow_d;
      total_q  <= total_d;
      left_q   <= left_d;
      lm_q     <= lm_d;
      nt_q     <= nt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign mem_rd_en       = rd_en_q;
  assign mem_addr        = addr_q;
  assign busy            = busy_q;
  assign result          = result_q;
  assign result_valid    = valid_q;
  assign total_count     = total_q;
  assign left_count      = left_q;
  assign leftmost_col    = lm_q;
  assign num_transitions = nt_q;

endmodule

// File: tb/tb_frame_classify_sequencer.sv
// Directed bench for frame_classify_sequencer: frame memory model, spec-level reference
// model feeding a scoreboard queue, latency/address-sequence checks and control scenarios.
module tb_frame_classify_sequencer;

  localparam int H   = 20;
  localparam int W   = 30;
  localparam int D   = 3;
  localparam int NB  = H * W * D;
  localparam int LAT = NB + 1 + (H - 2) + 1;

  logic        fpga_clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_rd_en;
  logic [10:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic [1:0]  result;
  logic        result_valid;
  logic        result_ack;
  logic [9:0]  total_count;
  logic [9:0]  left_count;
  logic [4:0]  leftmost_col;
  logic [4:0]  num_transitions;

  logic [7:0] frame [0:NB-1];

  typedef struct packed {
    logic [1:0] res;
    logic [9:0] tot;
    logic [9:0] lft;
    logic [4:0] lm;
    logic [4:0] nt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 fpga_clk = ~fpga_clk;

  always @(posedge fpga_clk) begin
    if (mem_rd_en) mem_rdata <= frame[mem_addr];
  end

  frame_classify_sequencer dut (
    .fpga_clk        (fpga_clk),
    .rst             (rst),
    .start           (start),
    .mem_rd_en       (mem_rd_en),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .busy            (busy),
    .result          (result),
    .result_valid    (result_valid),
    .result_ack      (result_ack),
    .total_count     (total_count),
    .left_count      (left_count),
    .leftmost_col    (leftmost_col),
    .num_transitions (num_transitions)
  );

  task automatic tick();
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic set_px(input int r, input int c, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] v);
    frame[(r * W + c) * D + 0] = a;
    frame[(r * W + c) * D + 1] = b;
    frame[(r * W + c) * D + 2] = v;
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] b, input logic [7:0] v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) set_px(r, c, a, b, v);
  endtask

  task automatic fill_pattern();
    fill(8'd0, 8'd0, 8'd0);
    for (int r = 0; r < H; r++) begin
      set_px(r, 5, 8'd30, 8'd200, 8'd200);
      if (r != 3 && r != 4 && r != 9 && r != 10) set_px(r, 7, 8'd30, 8'd200, 8'd200);
    end
  endtask

  function automatic bit in_b(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Reference model straight from the classification rules.
  task automatic model(output exp_t e);
    bit m [H][W];
    int tot, lft, lm, nt, base;
    bit a, b;
    tot = 0; lft = 0; lm = W; nt = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        base = (r * W + c) * D;
        m[r][c] = in_b(int'(frame[base]), 18, 43) && in_b(int'(frame[base + 1]), 25, 255) &&
                  in_b(int'(frame[base + 2]), 25, 255);
        if (m[r][c]) begin
          tot++;
          if (c < 12) lft++;
          if (c < lm) lm = c;
        end
      end
    end
    if (lm != W) begin
      for (int r = 0; r <= H - 3; r++) begin
        a = m[r][lm];
        b = (lm + 2 < W) ? m[r][lm + 2] : 1'b0;
        if (a != b) nt++;
      end
    end
    e.res = (nt == 4) ? 2'b10 : ((lft > 120) ? 2'b01 : 2'b00);
    e.tot = 10'(tot);
    e.lft = 10'(lft);
    e.lm  = 5'(lm);
    e.nt  = 5'(nt);
  endtask

  task automatic run_frame(input bit with_ack, input bit glitch, input int reset_at,
                           input string name);
    exp_t e, got;
    int   cyc, reads, bad;
    logic [10:0] ea;
    model(e);
    sb_q.push_back(e);
    start = 1'b1;
    result_ack = with_ack;
    cyc = 0; reads = 0; bad = 0; ea = 11'd0;
    while (cyc < LAT + 50) begin
      tick();
      cyc++;
      start = glitch && (cyc == 500 || cyc == 1810);
      result_ack = 1'b0;
      if (cyc == 1) begin
        check({name, "_first_rd_en"}, 32'(mem_rd_en), 32'd1);
        check({name, "_first_addr"}, 32'(mem_addr), 32'd0);
        check({name, "_first_valid"}, 32'(result_valid), 32'd0);
        check({name, "_first_busy"}, 32'(busy), 32'd1);
      end
      if (mem_rd_en) begin
        reads++;
        if (mem_addr !== ea) bad++;
        ea = ea + 11'd1;
      end
      if (reset_at >= 0 && mem_rd_en && (32'(mem_addr) == 32'(reset_at))) begin
        rst = 1'b1;
        tick();
        check({name, "_rst_busy"}, 32'(busy), 32'd0);
        check({name, "_rst_rd_en"}, 32'(mem_rd_en), 32'd0);
        check({name, "_rst_valid"}, 32'(result_valid), 32'd0);
        check({name, "_rst_result"}, 32'(result), 32'd0);
        check({name, "_rst_total"}, 32'(total_count), 32'd0);
        check({name, "_rst_left"}, 32'(left_count), 32'd0);
        check({name, "_rst_leftmost"}, 32'(leftmost_col), 32'd30);
        check({name, "_rst_trans"}, 32'(num_transitions), 32'd0);
        check({name, "_rst_addr"}, 32'(mem_addr), 32'd0);
        rst = 1'b0;
        sb_q.delete();
        return;
      end
      if (result_valid) break;
    end
    check({name, "_latency"}, 32'(cyc), 32'(LAT));
    check({name, "_read_count"}, 32'(reads), 32'(NB));
    check({name, "_addr_seq_bad"}, 32'(bad), 32'd0);
    check({name, "_busy_done"}, 32'(busy), 32'd0);
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check({name, "_result"}, 32'(result), 32'(got.res));
      check({name, "_total"}, 32'(total_count), 32'(got.tot));
      check({name, "_left"}, 32'(left_count), 32'(got.lft));
      check({name, "_leftmost"}, 32'(leftmost_col), 32'(got.lm));
      check({name, "_trans"}, 32'(num_transitions), 32'(got.nt));
    end
  endtask

  task automatic ack_result(input string name);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check({name, "_ack_valid_drop"}, 32'(result_valid), 32'd0);
    check({name, "_ack_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] c0_tab [0:4];
    logic [7:0] c1_tab [0:4];
    rst = 1'b1;
    start = 1'b0;
    result_ack = 1'b0;
    fill(8'd0, 8'd0, 8'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rd_en", 32'(mem_rd_en), 32'd0);
    check("reset_valid", 32'(result_valid), 32'd0);
    check("reset_total", 32'(total_count), 32'd0);
    check("reset_leftmost", 32'(leftmost_col), 32'd30);
    check("reset_trans", 32'(num_transitions), 32'd0);

    // Test 1: empty frame.
    run_frame(1'b0, 1'b0, -1, "zero");
    check("zero_result_const", 32'(result), 32'd0);
    check("zero_leftmost_const", 32'(leftmost_col), 32'd30);
    ack_result("zero");

    // Test 2: all green, then hold and ack behaviour.
    fill(8'd30, 8'd200, 8'd200);
    run_frame(1'b0, 1'b0, -1, "green");
    check("green_result_const", 32'(result), 32'd1);
    tick(); tick();
    check("green_hold_valid", 32'(result_valid), 32'd1);
    check("green_hold_result", 32'(result), 32'd1);
    ack_result("green");
    check("green_after_ack_total", 32'(total_count), 32'd600);
    check("green_after_ack_left", 32'(left_count), 32'd240);

    // Test 3: four-transition pattern.
    fill_pattern();
    run_frame(1'b0, 1'b0, -1, "pattern");
    check("pattern_result_const", 32'(result), 32'd2);
    check("pattern_total_const", 32'(total_count), 32'd36);
    ack_result("pattern");

    // Test 4: inclusive bounds on a single pixel at (0,0).
    c0_tab[0] = 8'd17; c1_tab[0] = 8'd200;
    c0_tab[1] = 8'd18; c1_tab[1] = 8'd200;
    c0_tab[2] = 8'd43; c1_tab[2] = 8'd200;
    c0_tab[3] = 8'd44; c1_tab[3] = 8'd200;
    c0_tab[4] = 8'd30; c1_tab[4] = 8'd24;
    for (int i = 0; i < 5; i++) begin
      fill(8'd0, 8'd0, 8'd0);
      set_px(0, 0, c0_tab[i], c1_tab[i], 8'd200);
      run_frame(1'b0, 1'b0, -1, $sformatf("bounds%0d", i));
      ack_result("bounds");
    end

    // Test 5: reset mid-scan, then a clean rescan.
    fill(8'd30, 8'd200, 8'd200);
    run_frame(1'b0, 1'b0, 900, "midrst");
    run_frame(1'b0, 1'b0, -1, "rescan");
    ack_result("rescan");

    // Test 6: start pulses in SCAN/TRANS ignored; start+ack in DONE restarts.
    fill_pattern();
    run_frame(1'b0, 1'b1, -1, "glitch");
    fill(8'd0, 8'd0, 8'd0);
    run_frame(1'b1, 1'b0, -1, "restart");
    ack_result("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_classify_sequencer.md
Name: frame_classify_sequencer

Overview:
Sequences green-object classification over the stored RGB frame buffer once a frame has been fully loaded from the Pi link.
- Pass 1 streams every byte out of the frame memory through a synchronous read port.
- It thresholds each pixel against per-channel green bounds and builds an internal 1-bit mask plus feature counters.
- Pass 2 walks the mask rows to count edge transitions.
- A 2-bit class result is then presented with a valid/ack handshake, for the LED/output logic.

Parameters:
HEIGHT, 20, frame rows
WIDTH, 30, frame columns
DEPTH, 3, channels per pixel; channel 0 = hue-like, 1 and 2 = saturation/value-like
ADDR_W, 11, frame memory address width (must cover HEIGHT*WIDTH*DEPTH)
SHIFT, 2, column offset for transition compare
LEFT, 12, columns 0..LEFT-1 form the "left" region
LEFT_THRESH, 120, left_count strictly above this gives class 01
LO0/HI0, 18/43, inclusive channel-0 bounds
LO1/HI1, 25/255, inclusive channel-1 bounds
LO2/HI2, 25/255, inclusive channel-2 bounds

Ports:
fpga_clk  in  1  system clock; single clock domain, all logic on its rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: frame loaded, begin classification
mem_rd_en  out  1  frame memory read strobe
mem_addr  out  ADDR_W  byte address = (row*WIDTH+col)*DEPTH+ch
mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd_en
busy  out  1  high from start acceptance until DONE is entered
result  out  2  10 = four transitions, 01 = left-heavy, 00 = other
result_valid  out  1  result/debug outputs are valid
result_ack  in  1  consumer accepts result
total_count  out  10  mask pixels set
left_count  out  10  mask pixels set in columns < LEFT
leftmost_col  out  5  smallest set column; WIDTH if the mask is empty
num_transitions  out  5  transition count from pass 2

Behaviour:
- States: IDLE, SCAN, DRAIN, TRANS, DONE.
- Reset, in any state and including mid-scan:
  - State goes to IDLE.
  - All outputs and counters are 0, except leftmost_col = WIDTH.
  - The mask register is cleared.
  - Any in-flight read data is discarded.
- IDLE: start → SCAN.
  - Counters clear, leftmost_col = WIDTH, busy = 1.
- SCAN: mem_rd_en = 1 every cycle, mem_addr = 0, 1, … HEIGHT*WIDTH*DEPTH-1.
  - After issuing the last address, go to DRAIN.
  - Total SCAN duration is HEIGHT*WIDTH*DEPTH cycles.
- Returned data:
  - Track the channel index with a registered copy of the issued address's channel.
  - Channel 0 and 1 compare results are latched.
  - When channel 2 returns, pixel mask = (LO0≤c0≤HI0) & (LO1≤c1≤HI1) & (LO2≤c2≤HI2).
  - Write the mask bit at [row][col].
  - If the mask bit is set: total_count += 1; left_count += 1 if col < LEFT; leftmost_col = min(leftmost_col, col).
- DRAIN: 1 cycle, mem_rd_en = 0, consumes the final channel-2 byte, then → TRANS.
- TRANS: one row per cycle, r = 0 … HEIGHT-3, so HEIGHT-2 cycles.
  - Compare mask[r][L] with mask[r][L+SHIFT], where L = leftmost_col.
  - Increment num_transitions on inequality.
  - If L+SHIFT ≥ WIDTH, the out-of-range bit reads as 0.
  - If L == WIDTH (empty mask), skip the compare; num_transitions stays 0.
- After the last row, register result and go to DONE.
  - result = 10 if num_transitions == 4.
  - Otherwise result = 01 if left_count > LEFT_THRESH.
  - Otherwise result = 00.
  - busy = 0, result_valid = 1.
- DONE: result and debug outputs are held stable.
  - result_ack → IDLE; result_valid drops the next cycle. The debug counters hold their values until the next start.
  - start in DONE (with or without ack; start has priority) → SCAN directly, counters clear, result_valid = 0.
- Start is ignored in SCAN, DRAIN and TRANS; no restart and no queuing.
- result_ack is ignored outside DONE.
- Latency from start accepted to result_valid: HEIGHT*WIDTH*DEPTH + 1 + (HEIGHT-2) + 1 cycles. With defaults this is 1800+1+18+1 = 1820.
- Counter widths saturate-free by construction: max 600 fits in 10 bits.

Test Plan:
1. All-zero frame, start → result 00, total_count 0, left_count 0, leftmost_col 30, num_transitions 0; result_valid exactly 1820 cycles after start; exactly 1800 read strobes, addresses 0..1799 in order.
2. Every pixel (30,200,200) → total 600, left 240, leftmost 0, transitions 0, result 01; ack returns to IDLE and result_valid drops the next cycle.
3. Green pixels at column 5 on all rows, and at column 7 on all rows except 3, 4, 9, 10 → leftmost 5, transitions 4, total 36, result 10.
4. Bounds check:
   - Single pixel at (row 0, col 0) with c0 = 17 → total 0.
   - Same pixel with c0 = 18 or 43 → total 1.
   - c0 = 44 → total 0.
   - c1 = 24 → total 0.
5. Assert rst during SCAN at address 900 → next cycle IDLE, busy 0, mem_rd_en 0, outputs 0 and leftmost 30; a subsequent start rescans from address 0 with correct results.
6. Start pulses during SCAN and TRANS → ignored, and the address sequence continues unbroken. Start in DONE with result_ack also high → new scan begins at address 0 and result_valid clears.
